// File: rtl/pam4_symbol_sched.sv
// Two-source PAM4 symbol scheduler: per-source FIFOs, mode-selected arbitration,
// paced output (at most one symbol every other cycle). Optional drop counter: PAM4_SCHED_OVF_CNT_EN.
module pam4_symbol_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       s0_symbol,
  input  logic             s0_valid,
  input  logic [1:0]       s1_symbol,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [1:0]       mode,
  input  logic             flush,
`ifdef PAM4_SCHED_OVF_CNT_EN
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count,
`endif
  output logic [1:0]       symbol_out,
  output logic             symbol_out_valid,
  output logic             src_id,
  output logic             busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_INC = (AW+1)'(1);

  typedef enum logic [1:0] {
    MODE_S0   = 2'b00,
    MODE_S1   = 2'b01,
    MODE_RR   = 2'b10,
    MODE_PRIO = 2'b11
  } mode_e;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic [1:0]  s0_mem_q [FIFO_DEPTH];
  logic [1:0]  s0_mem_d [FIFO_DEPTH];
  logic [1:0]  s1_mem_q [FIFO_DEPTH];
  logic [1:0]  s1_mem_d [FIFO_DEPTH];
  logic [AW:0] s0_wr_q, s0_wr_d, s0_rd_q, s0_rd_d;
  logic [AW:0] s1_wr_q, s1_wr_d, s1_rd_q, s1_rd_d;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  symbol_q, symbol_d;
  logic        src_q, src_d;
  logic        rr_q, rr_d;
  logic        ready_q;

  logic        s0_empty, s0_full, s1_empty, s1_full;
  logic        s0_elig, s1_elig, grant_s0, grant_s1;
  mode_e       mode_sel;

  assign mode_sel = mode_e'(mode);
  assign s0_empty = (s0_wr_q == s0_rd_q);
  assign s1_empty = (s1_wr_q == s1_rd_q);
  assign s0_full  = (s0_wr_q[AW] != s0_rd_q[AW]) && (s0_wr_q[AW-1:0] == s0_rd_q[AW-1:0]);
  assign s1_full  = (s1_wr_q[AW] != s1_rd_q[AW]) && (s1_wr_q[AW-1:0] == s1_rd_q[AW-1:0]);

  // ready_q holds s1_ready low through reset and the first edge after release
  assign s1_ready         = ready_q && !s1_full;
  assign symbol_out       = symbol_q;
  assign symbol_out_valid = out_valid_q;
  assign src_id           = src_q;
  assign busy             = !s0_empty || !s1_empty || out_valid_q;

  always_comb begin
    s0_elig  = !s0_empty && (mode_sel != MODE_S1);
    s1_elig  = !s1_empty && (mode_sel != MODE_S0);
    grant_s0 = 1'b0;
    grant_s1 = 1'b0;
    if (!out_valid_q) begin
      if (mode_sel == MODE_RR && s0_elig && s1_elig) begin
        grant_s0 = !rr_q;
        grant_s1 = rr_q;
      end else if (s0_elig) begin
        grant_s0 = 1'b1;
      end else if (s1_elig) begin
        grant_s1 = 1'b1;
      end
    end
  end

  always_comb begin
    s0_mem_d    = s0_mem_q;
    s1_mem_d    = s1_mem_q;
    s0_wr_d     = s0_wr_q;
    s0_rd_d     = s0_rd_q;
    s1_wr_d     = s1_wr_q;
    s1_rd_d     = s1_rd_q;
    out_valid_d = 1'b0;
    symbol_d    = symbol_q;
    src_d       = src_q;
    rr_d        = rr_q;
    if (flush) begin
      s0_rd_d = s0_wr_q;
      s1_rd_d = s1_wr_q;
    end else begin
      if (grant_s0) begin
        symbol_d = s0_mem_q[s0_rd_q[AW-1:0]];
        src_d    = 1'b0;
        s0_rd_d  = s0_rd_q + PTR_INC;
      end
      if (grant_s1) begin
        symbol_d = s1_mem_q[s1_rd_q[AW-1:0]];
        src_d    = 1'b1;
        s1_rd_d  = s1_rd_q + PTR_INC;
      end
      out_valid_d = grant_s0 || grant_s1;
      if (mode_sel == MODE_RR && (grant_s0 || grant_s1)) begin
        rr_d = grant_s0;
      end
      // A full s0 FIFO still accepts when its head leaves in the same cycle
      if (s0_valid && (!s0_full || grant_s0)) begin
        s0_mem_d[s0_wr_q[AW-1:0]] = s0_symbol;
        s0_wr_d = s0_wr_q + PTR_INC;
      end
      if (s1_valid && s1_ready) begin
        s1_mem_d[s1_wr_q[AW-1:0]] = s1_symbol;
        s1_wr_d = s1_wr_q + PTR_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_mem_q    <= '{default: '0};
      s1_mem_q    <= '{default: '0};
      s0_wr_q     <= '0;
      s0_rd_q     <= '0;
      s1_wr_q     <= '0;
      s1_rd_q     <= '0;
      out_valid_q <= 1'b0;
      symbol_q    <= 2'b00;
      src_q       <= 1'b0;
      rr_q        <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      s0_mem_q    <= s0_mem_d;
      s1_mem_q    <= s1_mem_d;
      s0_wr_q     <= s0_wr_d;
      s0_rd_q     <= s0_rd_d;
      s1_wr_q     <= s1_wr_d;
      s1_rd_q     <= s1_rd_d;
      out_valid_q <= out_valid_d;
      symbol_q    <= symbol_d;
      src_q       <= src_d;
      rr_q        <= rr_d;
      ready_q     <= 1'b1;
    end
  end

`ifdef PAM4_SCHED_OVF_CNT_EN
  logic             s0_drop;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  assign s0_drop   = s0_valid && s0_full && !grant_s0 && !flush;
  assign ovf_count = ovf_q;

  // Clear takes priority but still counts a drop landing in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = s0_drop ? CNT_W'(1) : '0;
    end else if (s0_drop && !(&ovf_q)) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule
